// File: rtl/alu_pkg.sv
// Shared ALU control codes and FSM state encoding for the sequential ALU.
package alu_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SHW   = 5;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SRLV = 4'b1011,
        OP_SRL  = 4'b1100,
        OP_SRA  = 4'b1101,
        OP_SLLV = 4'b1110
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_op(input logic [3:0] code);
        return (code == OP_SRL) || (code == OP_SRA) || (code == OP_SRLV) || (code == OP_SLLV);
    endfunction

endpackage

// File: rtl/serial_shifter.sv
// One-bit-per-cycle shifter: load captures value/amount/mode, then shifts until the count hits 0.
module serial_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [SHW-1:0]   amount,
    input  logic [WIDTH-1:0] value,
    input  logic             left,
    input  logic             arith,
    output logic             busy,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;
    logic             is_left;
    logic             is_arith;

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc      <= '0;
            cnt      <= '0;
            is_left  <= 1'b0;
            is_arith <= 1'b0;
        end else if (load) begin
            acc      <= value;
            cnt      <= amount;
            is_left  <= left;
            is_arith <= arith;
        end else if (cnt != '0) begin
            if (is_left) begin
                acc <= {acc[WIDTH-2:0], 1'b0};
            end else begin
                // Fill bit is the sign only for arithmetic shifts.
                acc <= {is_arith & acc[WIDTH-1], acc[WIDTH-1:1]};
            end
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);
    assign out  = acc;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops and bit-serial shifts behind a start/done handshake.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = alu_pkg::WIDTH,
    parameter int unsigned SHW   = alu_pkg::SHW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [SHW-1:0]   shamt,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);

    state_t           state;
    logic             accept;
    logic             load;
    logic [SHW-1:0]   sh_amount;
    logic             sh_busy;
    logic [WIDTH-1:0] sh_out;
    logic [WIDTH-1:0] alu_res;

    assign ready  = (state != SHIFT);
    assign done   = (state == DONE);
    assign accept = start & ready;
    assign load   = accept & is_shift_op(alucontrol);

    // Immediate forms take shamt; variable forms take the low bits of srca.
    assign sh_amount = ((alucontrol == OP_SRL) || (alucontrol == OP_SRA)) ? shamt
                                                                          : srca[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (alucontrol)
            OP_ADD:  alu_res = srca + srcb;
            OP_SUB:  alu_res = srca - srcb;
            OP_AND:  alu_res = srca & srcb;
            OP_OR:   alu_res = srca | srcb;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
            default: alu_res = '0;
        endcase
    end

    serial_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .amount (sh_amount),
        .value  (srcb),
        .left   (alucontrol == OP_SLLV),
        .arith  (alucontrol == OP_SRA),
        .busy   (sh_busy),
        .out    (sh_out)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            result <= '0;
            zero   <= 1'b1;
            err    <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    if (!sh_busy) begin
                        result <= sh_out;
                        zero   <= (sh_out == '0);
                        err    <= 1'b0;
                        state  <= DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        case (alucontrol)
                            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                                result <= alu_res;
                                zero   <= (alu_res == '0);
                                err    <= 1'b0;
                                state  <= DONE;
                            end
                            OP_SRL, OP_SRA, OP_SRLV, OP_SLLV: begin
                                state <= SHIFT;
                            end
                            default: begin
                                result <= '0;
                                zero   <= 1'b1;
                                err    <= 1'b1;
                                state  <= DONE;
                            end
                        endcase
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu.
module tb_seq_alu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  alucontrol;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [4:0]  shamt;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    seq_alu dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alucontrol (alucontrol),
        .srca       (srca),
        .srcb       (srcb),
        .shamt      (shamt),
        .ready      (ready),
        .done       (done),
        .result     (result),
        .zero       (zero),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        alucontrol = op;
        srca       = a;
        srcb       = b;
        shamt      = sh;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    // k = cycle index (1 = cycle after acceptance) at which done is seen; bounded.
    task automatic wait_done(output int k, output int low);
        k   = 1;
        low = ready ? 0 : 1;
        while (!done && k < 100) begin
            step();
            k++;
            if (!ready) low++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (result !== 32'h0) begin
            $display("FAIL reset_result got %h want %h", result, 32'h0); n_bad++;
        end
        n_cmp++;
        if (zero !== 1'b1 || err !== 1'b0) begin
            $display("FAIL reset_flags got zero=%b err=%b want zero=1 err=0", zero, err); n_bad++;
        end
        n_cmp++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            $display("FAIL reset_hs got done=%b ready=%b want done=0 ready=1", done, ready);
            n_bad++;
        end
    endtask

    task automatic test_add();
        int k, low;
        issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0);
        wait_done(k, low);
        n_cmp++;
        if (k !== 1) begin
            $display("FAIL add_latency got %0d want 1", k); n_bad++;
        end
        n_cmp++;
        if (result !== 32'h8000_0000 || zero !== 1'b0 || err !== 1'b0) begin
            $display("FAIL add_result got %h z=%b e=%b want 80000000 z=0 e=0", result, zero, err);
            n_bad++;
        end
    endtask

    task automatic test_sub_slt();
        int k, low;
        issue(4'b0110, 32'd5, 32'd5, 5'd0);
        wait_done(k, low);
        n_cmp++;
        if (k !== 1 || result !== 32'h0 || zero !== 1'b1) begin
            $display("FAIL sub got k=%0d %h z=%b want k=1 0 z=1", k, result, zero); n_bad++;
        end
        issue(4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0);
        wait_done(k, low);
        n_cmp++;
        if (k !== 1 || result !== 32'h1 || zero !== 1'b0) begin
            $display("FAIL slt got k=%0d %h z=%b want k=1 1 z=0", k, result, zero); n_bad++;
        end
    endtask

    task automatic test_shift_right();
        int k, low;
        issue(4'b1101, 32'h0, 32'h8000_0000, 5'd4);
        wait_done(k, low);
        n_cmp++;
        if (k !== 6 || low !== 5) begin
            $display("FAIL sra_timing got k=%0d low=%0d want k=6 low=5", k, low); n_bad++;
        end
        n_cmp++;
        if (result !== 32'hF800_0000) begin
            $display("FAIL sra_result got %h want f8000000", result); n_bad++;
        end
        issue(4'b1100, 32'h0, 32'h8000_0000, 5'd4);
        wait_done(k, low);
        n_cmp++;
        if (k !== 6 || result !== 32'h0800_0000) begin
            $display("FAIL srl got k=%0d %h want k=6 08000000", k, result); n_bad++;
        end
        issue(4'b1011, 32'h0000_0003, 32'hF000_0000, 5'd9);
        wait_done(k, low);
        n_cmp++;
        if (k !== 5 || result !== 32'h1E00_0000) begin
            $display("FAIL srlv got k=%0d %h want k=5 1e000000", k, result); n_bad++;
        end
    endtask

    task automatic test_sllv();
        int k, low;
        issue(4'b1110, 32'h20, 32'h1234, 5'd7);
        wait_done(k, low);
        n_cmp++;
        if (k !== 2 || result !== 32'h1234) begin
            $display("FAIL sllv0 got k=%0d %h want k=2 00001234", k, result); n_bad++;
        end
        issue(4'b1110, 32'd31, 32'h1, 5'd0);
        wait_done(k, low);
        n_cmp++;
        if (k !== 33 || result !== 32'h8000_0000) begin
            $display("FAIL sllv31 got k=%0d %h want k=33 80000000", k, result); n_bad++;
        end
    endtask

    task automatic test_start_in_shift();
        int k, low, extra;
        issue(4'b1110, 32'd8, 32'h1, 5'd0);
        k = 1;
        repeat (3) begin
            alucontrol = 4'b0010;
            srca       = 32'h1;
            srcb       = 32'h1;
            start      = 1'b1;
            step();
            k++;
        end
        start = 1'b0;
        while (!done && k < 100) begin
            step();
            k++;
        end
        n_cmp++;
        if (k !== 10 || result !== 32'h100) begin
            $display("FAIL start_in_shift got k=%0d %h want k=10 00000100", k, result); n_bad++;
        end
        extra = 0;
        repeat (3) begin
            step();
            if (done) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            $display("FAIL no_extra_done got %0d pulses want 0", extra); n_bad++;
        end
    endtask

    task automatic test_back_to_back();
        int k, low;
        issue(4'b0010, 32'd1, 32'd2, 5'd0);
        n_cmp++;
        if (done !== 1'b1 || result !== 32'd3) begin
            $display("FAIL b2b_first got done=%b %h want done=1 00000003", done, result); n_bad++;
        end
        issue(4'b0001, 32'h00FF_0000, 32'h1, 5'd0);
        n_cmp++;
        if (done !== 1'b1 || result !== 32'h00FF_0001) begin
            $display("FAIL b2b_second got done=%b %h want done=1 00ff0001", done, result); n_bad++;
        end
        step();
        n_cmp++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            $display("FAIL b2b_idle got done=%b ready=%b want 0 1", done, ready); n_bad++;
        end
    endtask

    task automatic test_reset_mid_shift();
        int pulses;
        issue(4'b1110, 32'd20, 32'h1, 5'd0);
        repeat (10) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        n_cmp++;
        if (ready !== 1'b1 || done !== 1'b0 || result !== 32'h0 || zero !== 1'b1) begin
            $display("FAIL mid_reset got ready=%b done=%b %h z=%b want 1 0 0 1",
                     ready, done, result, zero);
            n_bad++;
        end
        pulses = 0;
        repeat (30) begin
            step();
            if (done) pulses++;
        end
        n_cmp++;
        if (pulses !== 0 || result !== 32'h0) begin
            $display("FAIL mid_reset_drop got pulses=%0d %h want 0 0", pulses, result); n_bad++;
        end
    endtask

    task automatic test_bad_code();
        int k, low;
        issue(4'b1111, 32'd5, 32'd7, 5'd0);
        wait_done(k, low);
        n_cmp++;
        if (k !== 1 || err !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin
            $display("FAIL bad_code got k=%0d e=%b %h z=%b want 1 1 0 1", k, err, result, zero);
            n_bad++;
        end
        issue(4'b0000, 32'hF0F0_FFFF, 32'h0FFF_00F0, 5'd0);
        wait_done(k, low);
        n_cmp++;
        if (err !== 1'b0 || result !== 32'h00F0_00F0 || zero !== 1'b0) begin
            $display("FAIL and_after_err got e=%b %h z=%b want 0 00f000f0 0", err, result, zero);
            n_bad++;
        end
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        alucontrol = 4'b0;
        srca       = '0;
        srcb       = '0;
        shamt      = '0;
        test_reset();
        test_add();
        test_sub_slt();
        test_shift_right();
        test_sllv();
        test_start_in_shift();
        test_back_to_back();
        test_reset_mid_shift();
        test_bad_code();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
